// File: rtl/alu_multicycle.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : alu_multicycle
//  Purpose  : Unsigned ALU with a valid/ready handshake. Most operations
//             complete in one cycle. Multiply (iterative shift-add) and
//             divide (restoring, in2/in1) each take WIDTH cycles.
//  Ports    : clk, rst (async, active-high)
//             in_valid/in_ready   - operation handshake (ready only in IDLE)
//             alu_in1, alu_in2    - WIDTH-bit operands
//             opcode              - 6-bit operation select
//             out_valid/out_ready - result handshake (result held in DONE)
//             wb_data             - registered WIDTH-bit result
//             out                 - wb_data[OUT_W-1:0]
//             flags               - {div_zero, overflow, carry, zero}
//  Revision : 1.0 - initial release
// ============================================================================
module alu_multicycle #(
    parameter int WIDTH = 16,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] alu_in1,
    input  logic [WIDTH-1:0] alu_in2,
    input  logic [5:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] wb_data,
    output logic [OUT_W-1:0] out,
    output logic [3:0]       flags
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // acc: running product in MUL, partial remainder (low WIDTH+1 bits) in DIV
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    // sh: multiplier bits in MUL, dividend shifting out / quotient shifting in for DIV
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic [WIDTH-1:0]   dvsr_q, dvsr_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [3:0]         flags_q, flags_d;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_single_res;
    logic               w_single_carry;
    logic [2*WIDTH-1:0] w_mul_nx;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH-1:0]   w_quo_nx;
    logic               w_last;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        sh_d    = sh_q;
        dvsr_d  = dvsr_q;
        res_d   = res_q;
        flags_d = flags_q;

        w_sum          = {1'b0, alu_in1} + {1'b0, alu_in2};
        w_single_res   = '0;
        w_single_carry = 1'b0;
        case (opcode)
            6'h00: begin
                w_single_res   = w_sum[WIDTH-1:0];
                w_single_carry = w_sum[WIDTH];
            end
            6'h01:   w_single_res = (alu_in1 >= alu_in2) ? (alu_in1 - alu_in2)
                                                         : (alu_in2 - alu_in1);
            6'h04:   w_single_res = {{(WIDTH-1){1'b0}}, (alu_in1 >= alu_in2)};
            6'h05:   w_single_res = alu_in1 & alu_in2;
            6'h06:   w_single_res = alu_in1 | alu_in2;
            6'h07:   w_single_res = ~(alu_in1 & alu_in2);
            6'h08:   w_single_res = ~(alu_in1 | alu_in2);
            6'h09:   w_single_res = alu_in1 ^ alu_in2;
            6'h0A:   w_single_res = ~(alu_in1 ^ alu_in2);
            6'h0B:   w_single_res = ~alu_in1;
            6'h0C:   w_single_res = ~alu_in2;
            default: w_single_res = '0;
        endcase

        w_last   = (cnt_q == CNT_W'(WIDTH - 1));
        w_mul_nx = sh_q[0] ? (acc_q + mcand_q) : acc_q;

        // Restoring step: bring in the next dividend bit, subtract the divisor
        // and keep the difference only if it did not go negative.
        w_rem_sh = {acc_q[WIDTH-1:0], sh_q[WIDTH-1]};
        w_trial  = w_rem_sh - {1'b0, dvsr_q};
        w_quo_nx = {sh_q[WIDTH-2:0], ~w_trial[WIDTH]};

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    cnt_d = '0;
                    acc_d = '0;
                    if (opcode == 6'h02) begin
                        mcand_d = {{WIDTH{1'b0}}, alu_in1};
                        sh_d    = alu_in2;
                        state_d = S_MUL;
                    end else if (opcode == 6'h03 && alu_in1 != '0) begin
                        sh_d    = alu_in2;
                        dvsr_d  = alu_in1;
                        state_d = S_DIV;
                    end else if (opcode == 6'h03) begin
                        res_d   = '1;
                        flags_d = 4'b1000;
                        state_d = S_DONE;
                    end else begin
                        res_d   = w_single_res;
                        flags_d = {2'b00, w_single_carry, (w_single_res == '0)};
                        state_d = S_DONE;
                    end
                end
            end
            S_MUL: begin
                acc_d   = w_mul_nx;
                mcand_d = mcand_q << 1;
                sh_d    = sh_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (w_last) begin
                    res_d   = w_mul_nx[WIDTH-1:0];
                    flags_d = {1'b0, (w_mul_nx[2*WIDTH-1:WIDTH] != '0), 1'b0,
                               (w_mul_nx[WIDTH-1:0] == '0)};
                    state_d = S_DONE;
                end
            end
            S_DIV: begin
                acc_d = {{(WIDTH-1){1'b0}}, (w_trial[WIDTH] ? w_rem_sh : w_trial)};
                sh_d  = w_quo_nx;
                cnt_d = cnt_q + CNT_W'(1);
                if (w_last) begin
                    res_d   = w_quo_nx;
                    flags_d = {3'b000, (w_quo_nx == '0)};
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            sh_q    <= '0;
            dvsr_q  <= '0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            sh_q    <= sh_d;
            dvsr_q  <= dvsr_d;
            res_q   <= res_d;
            flags_q <= flags_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign wb_data   = res_q;
    assign out       = res_q[OUT_W-1:0];
    assign flags     = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_multicycle.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_alu_multicycle
//  Purpose  : Self-checking bench for alu_multicycle (WIDTH=16, OUT_W=8).
//             Directed cases plus randomized operations compared against a
//             plain-arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_multicycle;

    localparam int WIDTH = 16;
    localparam int OUT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] alu_in1 = '0;
    logic [WIDTH-1:0] alu_in2 = '0;
    logic [5:0]       opcode = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] wb_data;
    logic [OUT_W-1:0] out;
    logic [3:0]       flags;

    int n_checks = 0;
    int n_errors = 0;

    alu_multicycle #(.WIDTH(WIDTH), .OUT_W(OUT_W)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_in1   (alu_in1),
        .alu_in2   (alu_in2),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .wb_data   (wb_data),
        .out       (out),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: result, flags and latency straight from the opcode rules.
    task automatic ref_model(input logic [5:0] op, input longint unsigned a,
                             input longint unsigned b, output longint unsigned res,
                             output logic [3:0] flg, output int lat);
        longint unsigned mask, full;
        logic dz, ov, cy;
        mask = (64'd1 << WIDTH) - 1;
        dz = 0; ov = 0; cy = 0; lat = 1;
        case (op)
            6'h00: begin full = a + b; res = full & mask; cy = (full > mask); end
            6'h01: res = (a >= b) ? a - b : b - a;
            6'h02: begin full = a * b; res = full & mask; ov = (full > mask); lat = WIDTH + 1; end
            6'h03: if (a == 0) begin res = mask; dz = 1; end
                   else begin res = b / a; lat = WIDTH + 1; end
            6'h04: res = (a >= b) ? 1 : 0;
            6'h05: res = a & b;
            6'h06: res = a | b;
            6'h07: res = ~(a & b) & mask;
            6'h08: res = ~(a | b) & mask;
            6'h09: res = a ^ b;
            6'h0A: res = ~(a ^ b) & mask;
            6'h0B: res = ~a & mask;
            6'h0C: res = ~b & mask;
            default: res = 0;
        endcase
        flg = {dz, ov, cy, (res == 0)};
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_op(input logic [5:0] op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input int hold, input bit check_busy);
        longint unsigned exp_res;
        logic [3:0]      exp_flg;
        int              exp_lat, lat;
        bit              busy_ok;
        ref_model(op, a, b, exp_res, exp_flg, exp_lat);
        check($sformatf("in_ready_idle op%0h", op), in_ready, 1'b1);
        opcode = op; alu_in1 = a; alu_in2 = b; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        alu_in1 = WIDTH'($urandom); alu_in2 = WIDTH'($urandom); opcode = 6'($urandom);
        lat = 1;
        busy_ok = 1'b1;
        while (!out_valid && lat < 100) begin
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (check_busy) check("in_ready_busy", busy_ok, 1'b1);
        check($sformatf("latency op%0h", op), lat, exp_lat);
        check($sformatf("wb_data op%0h a%0h b%0h", op, a, b), wb_data, exp_res[WIDTH-1:0]);
        check($sformatf("out op%0h", op), out, exp_res[OUT_W-1:0]);
        check($sformatf("flags op%0h a%0h b%0h", op, a, b), flags, exp_flg);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; opcode = 6'h00;
            @(negedge clk);
            check("hold_valid", out_valid, 1'b1);
            check("hold_ready", in_ready, 1'b0);
            check("hold_data", wb_data, exp_res[WIDTH-1:0]);
            check("hold_flags", flags, exp_flg);
        end
        // Drain with in_valid high: must not re-accept in the drain cycle.
        out_ready = 1'b1; in_valid = 1'b1; opcode = 6'h00;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        check("drain_valid", out_valid, 1'b0);
        check("drain_ready", in_ready, 1'b1);
    endtask

    initial begin
        // Reset values while rst is held, before any clock edge.
        #2;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_wb_data", wb_data, '0);
        check("rst_out", out, '0);
        check("rst_flags", flags, 4'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases.
        run_op(6'h00, 16'hFFFF, 16'h0002, 0, 1'b0);
        run_op(6'h01, 16'd3, 16'd10, 0, 1'b0);
        run_op(6'h04, 16'd5, 16'd5, 0, 1'b0);
        run_op(6'h04, 16'd4, 16'd5, 0, 1'b0);
        run_op(6'h02, 16'h0100, 16'h0101, 0, 1'b1);
        run_op(6'h03, 16'd7, 16'd100, 0, 1'b1);
        run_op(6'h03, 16'd0, 16'd5, 0, 1'b0);
        run_op(6'h2A, 16'h1234, 16'h0000, 0, 1'b0);
        run_op(6'h03, 16'd1, 16'hFFFF, 0, 1'b1);
        run_op(6'h02, 16'hFFFF, 16'hFFFF, 0, 1'b1);
        run_op(6'h09, 16'hA5A5, 16'h0FF0, 5, 1'b0);

        // Randomized operations with random backpressure.
        for (int n = 0; n < 60; n++) begin
            logic [5:0]       op;
            logic [WIDTH-1:0] a, b;
            op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'($urandom_range(0, 12));
            a  = WIDTH'($urandom);
            b  = WIDTH'($urandom);
            if ($urandom_range(0, 5) == 0) a = WIDTH'($urandom_range(0, 3));
            run_op(op, a, b, $urandom_range(0, 3), 1'b1);
        end

        // Reset in the middle of a multiply.
        opcode = 6'h02; alu_in1 = 16'h1234; alu_in2 = 16'h00FF; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_in_ready", in_ready, 1'b1);
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_wb_data", wb_data, '0);
        check("abort_out", out, '0);
        check("abort_flags", flags, 4'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (WIDTH + 2) begin
            @(negedge clk);
            check("abort_no_result", out_valid, 1'b0);
        end
        check("abort_wb_stays0", wb_data, '0);
        run_op(6'h00, 16'd1, 16'd1, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand and result width in bits (legal values 4..32).
REQ-002 The block SHALL have parameter OUT_W, default 8, giving the width of the low-byte display output (legal values 1..WIDTH).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, the reset; it is asynchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1, operands/opcode presented.
REQ-006 The block SHALL have port in_ready, output, 1, block can accept a new operation.
REQ-007 The block SHALL have port alu_in1, input, WIDTH, first operand.
REQ-008 The block SHALL have port alu_in2, input, WIDTH, second operand.
REQ-009 The block SHALL have port opcode, input, 6, operation select.
REQ-010 The block SHALL have port out_valid, output, 1, result available.
REQ-011 The block SHALL have port out_ready, input, 1, consumer accepts result.
REQ-012 The block SHALL have port wb_data, output, WIDTH, registered result.
REQ-013 The block SHALL have port out, output, OUT_W, equal to wb_data[OUT_W-1:0].
REQ-014 The block SHALL have port flags, output, 4, {div_zero, overflow, carry, zero}, registered with wb_data.

Function
REQ-015 The opcode map SHALL be as follows:
- 0x00 add.
- 0x01 |in1-in2| (in1>=in2 ? in1-in2 : in2-in1).
- 0x02 multiply.
- 0x03 divide in2/in1.
- 0x04 ge (1 if in1>=in2 else 0).
- 0x05 and; 0x06 or; 0x07 nand; 0x08 nor; 0x09 xor; 0x0A xnor.
- 0x0B ~in1; 0x0C ~in2.
- Any other code: result 0.
REQ-016 All comparisons and arithmetic SHALL be unsigned; results SHALL be truncated to the low WIDTH bits.
REQ-017 The FSM SHALL have states IDLE, MUL, DIV, DONE.
REQ-018 in_ready SHALL be 1 only in IDLE.
REQ-019 An operation SHALL be accepted on a clk edge with in_valid=1 and in_ready=1, latching alu_in1, alu_in2 and opcode; the inputs are don't-care afterwards.
REQ-020 Single-cycle opcodes (all except 0x02 and 0x03) SHALL go IDLE->DONE; out_valid rises on the edge after acceptance (latency 1).
REQ-021 Opcode 0x02 SHALL go IDLE->MUL and run an iterative shift-add over WIDTH cycles, then go MUL->DONE; out_valid is asserted exactly WIDTH+1 cycles after acceptance.
REQ-022 Opcode 0x03 with in1!=0 SHALL go IDLE->DIV and run a restoring divide over WIDTH cycles, then go DIV->DONE; latency is WIDTH+1 and the result is the quotient floor(in2/in1).
REQ-023 Opcode 0x03 with in1==0 SHALL go IDLE->DONE with latency 1, wb_data all-ones and div_zero=1.
REQ-024 In DONE, out_valid SHALL be 1, and wb_data, out and flags SHALL hold stable until out_ready=1; on that edge the block goes DONE->IDLE and out_valid falls.
REQ-025 A new operation SHALL NOT be accepted in the same cycle a result is drained; the earliest re-accept is the following cycle.
REQ-026 The zero flag SHALL be set when wb_data==0.
REQ-027 The carry flag SHALL be the carry-out for add (0x00) and 0 for all other opcodes.
REQ-028 The overflow flag SHALL be set for multiply when the full 2*WIDTH-bit product does not fit in WIDTH bits, and 0 otherwise.
REQ-029 The div_zero flag SHALL be set only as defined in REQ-023.
REQ-030 in_valid asserted while in_ready=0 SHALL be ignored, with no side effects.

Reset
REQ-031 While rst=1, regardless of clk, the state SHALL be IDLE and the outputs SHALL be: in_ready=1, out_valid=0, wb_data=0, out=0, flags=0.
REQ-032 Assertion of rst during MUL, DIV or DONE SHALL abort the operation; the partial result is discarded and never appears on wb_data.
REQ-033 After rst is released, the first operation SHALL be accepted on the first clk edge with in_valid=1.

Verification (WIDTH=16, OUT_W=8)
REQ-034 Add 0xFFFF+0x0002, out_ready=1 -> out_valid one cycle after accept, wb_data=0x0001, out=0x01, carry=1, zero=0.
REQ-035 Abs-diff with in1=3, in2=10 -> wb_data=0x0007; ge with in1=5, in2=5 -> wb_data=0x0001.
REQ-036 Multiply 0x0100*0x0101 -> out_valid exactly 17 cycles after accept, wb_data=0x0100, overflow=1, in_ready=0 throughout.
REQ-037 Divide in1=7, in2=100 -> wb_data=0x000E after 17 cycles; divide in1=0, in2=5 -> wb_data=0xFFFF, div_zero=1, latency 1.
REQ-038 Opcode 0x2A with in1=0x1234 -> wb_data=0, zero=1.
REQ-039 Backpressure and reset checks:
- Hold out_ready=0 for 5 cycles in DONE -> wb_data and flags unchanged, in_ready=0, an in_valid pulse is ignored.
- Assert rst at cycle 8 of a multiply -> all outputs 0 immediately, in_ready=1.
- After rst release, an add 1+1 -> wb_data=0x0002.
